adc_spi_interface: RTL and testbench
====================================

# adc_spi_interface

Serial front-end for the on-board 8-channel, 12-bit SPI ADC (ADC128S022-style protocol). It continuously round-robins channels 0–3 in back-to-back 16-clock frames and drives the ADC's CS, SCLK and DIN. Each returned sample goes into a per-channel holding register. It sits between the ADC pins and the sensor logic that reads the four IR distance channels.

## Interface
- NUM_CH, 4: channels scanned, 0..NUM_CH-1; ≤8.
- DATA_W, 12: sample width.
- clk  in  1: system clock; also the SCLK rate.
- reset  in  1: one clock; reset is asynchronous and active-high.
- ADC_Dout  in  1: ADC serial data out; changes after SCLK falling edge.
- ADC_Din  out  1: ADC serial data in (next-channel address).
- ADC_CS  out  1: ADC chip select, active low.
- ADC_clk  out  1: ADC SCLK.
- ADC_DATA  out  [DATA_W-1:0] x [NUM_CH-1:0] unpacked: latest sample per channel.

## Operation
- Reset (async): ADC_CS=1, ADC_Din=0, bit_cnt=0, cur_ch=0, shift register=0, all ADC_DATA[i]=0.
- ADC_clk = clk | ADC_CS. SCLK idles high while CS is high and follows clk while CS is low.
- First rising clk edge after reset deassertion: ADC_CS←0. From then on CS stays low; frames run back-to-back with no gap.
- Frame = 16 rising edges after CS low, bit_cnt 0..15. On each edge, sample ADC_Dout MSB-first into a 16-bit shift register, then bit_cnt++ (wrap 15→0).
- On the edge with bit_cnt==15, ADC_DATA[cur_ch] ← low DATA_W bits of {shift[14:0], ADC_Dout}. The 4 leading bits are discarded, even if nonzero. cur_ch ← (cur_ch+1) mod NUM_CH.
- ADC_Din is updated on falling clk edges. During frame positions 2,3,4 it carries ADD2,ADD1,ADD0 of next_ch = (cur_ch+1) mod NUM_CH; at all other positions it is 0.
- The ADC converts the addressed channel in the following frame. The ADC's power-up default is channel 0, so frame 0 returns ch0, frame 1 returns ch1, and so on.
- Other ADC_DATA entries hold their value until rewritten.

## Timing
- With reset released before rising edge E0, CS falls at E0. Data bit 15 is sampled at E1 and bit 0 at E16. ADC_DATA[0] is valid immediately after E16.
- Channel k of frame n is latched at edge E0+16(n+1). A full scan of 4 channels takes 64 clocks.
- Reset mid-frame: immediate abort. CS goes high and SCLK goes high. The partial sample is dropped and all ADC_DATA entries clear. The next frame restarts at ch0.
- ADC_Din is stable across each SCLK rising edge, changing half a period earlier.

## Structure
- Package adc_pkg: DATA_W, NUM_CH, FRAME_LEN=16, ADDR_BIT_FIRST=2, typedef adc_sample_t = logic [DATA_W-1:0].
- Optional sub-module adc_frame_shifter: bit counter plus 16-bit shift register. Outputs frame_done and sample.
- Top level holds CS/SCLK control, the channel pointer, DIN generation on negedge, and the ADC_DATA register file.

## Test plan
- Reset held, then released between edges: CS=1, ADC_clk=1 and ADC_DATA all 0 during reset. CS falls on the first rising edge after release.
- Serial model shifts 0xABCD then 0x1234 MSB-first, changing on falling edges: ADC_DATA[0]=0xBCD after 16 sample edges; ADC_DATA[1]=0x234 16 edges later.
- Continue with 0x5678 and 0x9ABC: ADC_DATA[2]=0x678 and ADC_DATA[3]=0xABC. The fifth frame (0x0FFF) overwrites ADC_DATA[0]=0xFFF, confirming wrap to ch0.
- Capture ADC_Din during frames 0..3 at positions 2–4: 001, 010, 011, 000. All other positions are 0.
- Assert reset at bit 8 of frame 1: CS goes high and ADC_clk goes high asynchronously, and ADC_DATA clears. After release, the next completed frame writes ADC_DATA[0].
- Leading bits nonzero (0xF123): ADC_DATA gets 0x123. Only the target channel changes; the other three entries keep their values.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants, types and helpers for the ADC128S022-style SPI front-end.
// Frame geometry and the address-bit window are fixed by the ADC protocol.

package adc_pkg;

    localparam int DATA_W         = 12;
    localparam int NUM_CH         = 4;
    localparam int FRAME_LEN      = 16;
    localparam int ADDR_BIT_FIRST = 2;
    localparam int CNT_W          = $clog2(FRAME_LEN);

    typedef logic [DATA_W-1:0] adc_sample_t;

    typedef enum logic [0:0] {
        CS_IDLE   = 1'b0,
        CS_ACTIVE = 1'b1
    } cs_state_e;

    function automatic logic [2:0] next_chan(input logic [2:0] ch, input int unsigned n);
        if ({29'd0, ch} + 32'd1 >= n) begin
            return 3'd0;
        end
        return ch + 3'd1;
    endfunction

endpackage

// File: rtl/adc_frame_shifter.sv
// Frame bit counter and MSB-first serial capture for one 16-clock ADC frame.
// The last bit is taken live from sdi so the full word is available on the final edge.

module adc_frame_shifter (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          sdi,
    output logic [adc_pkg::CNT_W-1:0]     bit_cnt,
    output logic                          frame_done,
    output logic [adc_pkg::FRAME_LEN-1:0] sample
);
    import adc_pkg::*;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-2:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (en) begin
            shift_d = {shift_q[FRAME_LEN-3:0], sdi};
            if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign bit_cnt    = cnt_q;
    assign frame_done = en && (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign sample     = {shift_q, sdi};

endmodule

// File: rtl/adc_spi_interface.sv
// SPI front-end that round-robins ADC channels 0..NUM_CH-1 in back-to-back frames
// and keeps the most recent sample of each channel in a holding register.

module adc_spi_interface #(
    parameter int NUM_CH = adc_pkg::NUM_CH,
    parameter int DATA_W = adc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ADC_Dout,
    output logic              ADC_Din,
    output logic              ADC_CS,
    output logic              ADC_clk,
    output logic [DATA_W-1:0] ADC_DATA [NUM_CH]
);
    import adc_pkg::*;

    cs_state_e state_q, state_d;

    logic [CNT_W-1:0]     bit_cnt;
    logic                 frame_done;
    logic [FRAME_LEN-1:0] sample;

    logic [2:0]        ch_q, ch_d;
    logic [2:0]        ch_nxt;
    logic              din_q, din_d;
    logic [DATA_W-1:0] data_q [NUM_CH];
    logic [DATA_W-1:0] data_d [NUM_CH];

    logic unused_lead;

    always_comb begin
        state_d = state_q;
        case (state_q)
            CS_IDLE:   state_d = CS_ACTIVE;
            CS_ACTIVE: state_d = CS_ACTIVE;
            default:   state_d = CS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign ADC_CS  = (state_q == CS_IDLE);
    assign ADC_clk = clk | ADC_CS;

    adc_frame_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .en         (~ADC_CS),
        .sdi        (ADC_Dout),
        .bit_cnt    (bit_cnt),
        .frame_done (frame_done),
        .sample     (sample)
    );

    // The leading frame bits carry no data; they are deliberately discarded.
    assign unused_lead = ^sample[FRAME_LEN-1:DATA_W];

    assign ch_nxt = next_chan(ch_q, NUM_CH);

    always_comb begin
        ch_d = ch_q;
        if (frame_done) begin
            ch_d = ch_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q <= '0;
        end else begin
            ch_q <= ch_d;
        end
    end

    // Address bits launch on the falling edge so they are stable at the next SCLK rise.
    always_comb begin
        din_d = 1'b0;
        case (bit_cnt)
            CNT_W'(ADDR_BIT_FIRST):     din_d = ch_nxt[2];
            CNT_W'(ADDR_BIT_FIRST + 1): din_d = ch_nxt[1];
            CNT_W'(ADDR_BIT_FIRST + 2): din_d = ch_nxt[0];
            default:                    din_d = 1'b0;
        endcase
        if (ADC_CS) begin
            din_d = 1'b0;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign ADC_Din = din_q;

    always_comb begin
        data_d = data_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (frame_done && (ch_q == 3'(i))) begin
                data_d[i] = sample[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q <= data_d;
        end
    end

    assign ADC_DATA = data_q;

endmodule

// File: tb/tb_adc_spi_interface.sv
// Directed bench for adc_spi_interface with a serial ADC model and a scoreboard.

module tb_adc_spi_interface;

    typedef struct packed {
        logic [1:0]  ch;
        logic [11:0] val;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        ADC_Dout;
    logic        ADC_Din;
    logic        ADC_CS;
    logic        ADC_clk;
    logic [11:0] adc_data [4];

    logic [15:0] words [$];
    exp_t        exp_q [$];
    logic [11:0] mirror [4];
    logic [1:0]  ch_m;
    logic [15:0] cur_word;
    int          pos;

    int vectors;
    int miscompares;

    adc_spi_interface #(.NUM_CH(4), .DATA_W(12)) dut (
        .clk      (clk),
        .reset    (reset),
        .ADC_Dout (ADC_Dout),
        .ADC_Din  (ADC_Din),
        .ADC_CS   (ADC_CS),
        .ADC_clk  (ADC_clk),
        .ADC_DATA (adc_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: shifts a word out MSB-first, changing after each falling edge.
    always @(negedge clk) begin
        if (reset || ADC_CS) begin
            pos      = 0;
            ADC_Dout = 1'b0;
        end else begin
            if (pos == 0) begin
                cur_word = (words.size() > 0) ? words.pop_front() : 16'h0000;
                exp_q.push_back('{ch: ch_m, val: cur_word[11:0]});
                ch_m = ch_m + 2'd1;
            end
            ADC_Dout = cur_word[15-pos];
            pos      = (pos + 1) % 16;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("%s_ch%0d", tag, c), {20'd0, adc_data[c]}, {20'd0, mirror[c]});
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        exp_q.delete();
        ch_m = 2'd0;
        for (int c = 0; c < 4; c++) mirror[c] = 12'h000;
        check("rst_cs_async", {31'd0, ADC_CS}, 32'd1);
        check("rst_sclk_async", {31'd0, ADC_clk}, 32'd1);
        check_data("rst_data");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_cs_held", {31'd0, ADC_CS}, 32'd1);
        check("rst_sclk_held", {31'd0, ADC_clk}, 32'd1);
        check("rst_din", {31'd0, ADC_Din}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("cs_fall_e0", {31'd0, ADC_CS}, 32'd0);
    endtask

    task automatic run_frame();
        exp_t        e;
        logic [15:0] din_cap;
        logic [15:0] din_exp;
        logic [2:0]  nx;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1;
            din_cap[i] = ADC_Din;
            @(posedge clk);
        end
        #1;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e  = exp_q.pop_front();
            mirror[e.ch] = e.val;
            nx = {1'b0, e.ch + 2'd1};
            din_exp    = '0;
            din_exp[2] = nx[2];
            din_exp[3] = nx[1];
            din_exp[4] = nx[0];
            check($sformatf("din_addr_ch%0d", e.ch), {16'd0, din_cap}, {16'd0, din_exp});
            check_data($sformatf("frame_ch%0d", e.ch));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        ADC_Dout    = 1'b0;
        pos         = 0;
        ch_m        = 2'd0;
        cur_word    = 16'h0000;
        words.push_back(16'hABCD);
        words.push_back(16'h1234);
        words.push_back(16'h5678);
        words.push_back(16'h9ABC);
        words.push_back(16'h0FFF);
        words.push_back(16'h3A5A);

        apply_reset();
        repeat (6) run_frame();

        words.push_back(16'h0321);
        words.push_back(16'h7777);
        apply_reset();
        run_frame();

        // Abort frame 1 at bit 8 while SCLK is low to expose the async path.
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1;
        words.push_back(16'h0555);
        words.push_back(16'hF123);
        apply_reset();
        run_frame();
        run_frame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
